// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch stage: FSM state encoding and prefetch entry layout.
// Entry widths track the instr_fetch defaults (16-bit words, 8-bit word addresses).
package ifetch_pkg;

    localparam int IFETCH_DW = 16;
    localparam int IFETCH_AW = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [IFETCH_AW-1:0] pc;
        logic [IFETCH_DW-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Sync FIFO of entries with combinational head; push/pop take effect at the clock edge, flush empties it.
// Latency: push visible at head the next cycle. Backpressure: caller must not push when full unless popping.
module ifetch_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     push_dat,
    input  logic pop,
    input  logic flush,
    output T     head,
    output logic full,
    output logic empty
);
    localparam int PW = $clog2(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC + FSM drive an async-read RAM, words land in a prefetch FIFO presented as {pc, instr}.
// Latency: address in cycle N -> instr_valid_o in N+1; fetch stalls when the FIFO is full and not popping.
// IFETCH_PERF_EN adds wrapping 16-bit fetch and stall counters.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int DATA_WIDTH = IFETCH_DW,
    parameter int ADDR_WIDTH = IFETCH_AW,
    parameter int FIFO_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  halt_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_cs_o,
    output logic                  mem_oe_o,
    output logic                  mem_we_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  busy_o
`ifdef IFETCH_PERF_EN
    ,
    output logic [15:0]           perf_fetch_cnt_o,
    output logic [15:0]           perf_stall_cnt_o
`endif
);
    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  fetch_en;
    fetch_entry_t          push_entry;
    fetch_entry_t          head;

    assign pop      = ~empty & instr_ready_i;
    assign fetch_en = (state == S_FETCH) & ~redirect_valid_i & (~full | pop);

    assign mem_addr_o    = pc;
    assign pc_o          = pc;
    assign mem_cs_o      = fetch_en;
    assign mem_oe_o      = fetch_en;
    assign mem_we_o      = 1'b0;
    assign instr_valid_o = ~empty;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;
    assign busy_o        = (state != S_IDLE) | ~empty;

    assign push_entry = '{pc: pc, instr: mem_data_i};

    // A redirect flushes after any same-cycle pop; fetch_en is already low so nothing is pushed.
    ifetch_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fetch_en),
        .push_dat (push_entry),
        .pop      (pop),
        .flush    (redirect_valid_i),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
        end else if (redirect_valid_i) begin
            pc <= redirect_pc_i;
            if (halt_i) begin
                state <= S_HALT;
            end
        end else begin
            if (fetch_en) begin
                pc <= pc + 1'b1;
            end
            // halt outranks start even when halt has no effect in the current state
            if (halt_i) begin
                if (state == S_FETCH) begin
                    state <= S_HALT;
                end
            end else if (start_i && state != S_FETCH) begin
                state <= S_FETCH;
            end
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_cnt_o <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (fetch_en) begin
                perf_fetch_cnt_o <= perf_fetch_cnt_o + 1'b1;
            end
            if (state == S_FETCH && !fetch_en && !redirect_valid_i) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic against a queue-based fetch model.
// The driver pushes expected {pc, instr} entries; a negedge monitor pops them on every handshake.
module tb_instr_fetch;

    localparam int DEPTH = 2;
    localparam int M_IDLE = 0, M_FETCH = 1, M_HALT = 2;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, halt = 1'b0, redir = 1'b0, ready = 1'b0;
    logic [7:0]  rpc = '0;
    logic [7:0]  mem_addr, instr_pc, pc_o;
    logic        mem_cs, mem_oe, mem_we, instr_valid, busy;
    logic [15:0] mem_data, instr;
`ifdef IFETCH_PERF_EN
    logic [15:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    logic [15:0] mem [256];
    assign mem_data = mem[mem_addr];

    instr_fetch #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (8),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (8'h00)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start),
        .halt_i           (halt),
        .redirect_valid_i (redir),
        .redirect_pc_i    (rpc),
        .mem_addr_o       (mem_addr),
        .mem_cs_o         (mem_cs),
        .mem_oe_o         (mem_oe),
        .mem_we_o         (mem_we),
        .mem_data_i       (mem_data),
        .instr_valid_o    (instr_valid),
        .instr_o          (instr),
        .instr_pc_o       (instr_pc),
        .instr_ready_i    (ready),
        .pc_o             (pc_o),
        .busy_o           (busy)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt),
        .perf_stall_cnt_o (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    exp_t        expq[$];
    int          m_state;
    logic [7:0]  m_pc;
    bit          flush_pend;
    logic [15:0] m_fetch, m_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && instr_valid === 1'b1 && ready === 1'b1) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_instr: got pc %0h instr %0h expected none", instr_pc, instr);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("instr", instr, e.instr);
                check("instr_pc", instr_pc, e.pc);
            end
        end
    end

    // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
    task automatic step(input bit s, input bit h, input bit r, input logic [7:0] rp, input bit rd);
        int  qn;
        bit  pop_m, fe;
        @(posedge clk);
        #1;
        start = s; halt = h; redir = r; rpc = rp; ready = rd;
        if (flush_pend) begin
            expq.delete();
            flush_pend = 0;
        end
        #3;
        qn    = expq.size();
        pop_m = (qn > 0) && rd;
        fe    = (m_state == M_FETCH) && !r && ((qn < DEPTH) || pop_m);
        check("valid", instr_valid, qn > 0);
        check("cs", mem_cs, fe);
        check("oe", mem_oe, fe);
        check("we", mem_we, 0);
        check("addr", mem_addr, m_pc);
        check("pc", pc_o, m_pc);
        check("busy", busy, (m_state != M_IDLE) || (qn > 0));
`ifdef IFETCH_PERF_EN
        check("fetch_cnt", perf_fetch_cnt, m_fetch);
        check("stall_cnt", perf_stall_cnt, m_stall);
`endif
        if (fe) m_fetch = m_fetch + 1;
        if (m_state == M_FETCH && !fe && !r) m_stall = m_stall + 1;
        if (r) begin
            m_pc = rp;
            flush_pend = 1;
            if (h) m_state = M_HALT;
        end else begin
            if (fe) begin
                expq.push_back('{pc: m_pc, instr: mem[m_pc]});
                m_pc = m_pc + 8'd1;
            end
            if (h) begin
                if (m_state == M_FETCH) m_state = M_HALT;
            end else if (s && m_state != M_FETCH) begin
                m_state = M_FETCH;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 0; start = 0; halt = 0; redir = 0; ready = 0;
        @(posedge clk);
        #3;
        check("rst_valid", instr_valid, 0);
        check("rst_cs", mem_cs, 0);
        check("rst_oe", mem_oe, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_pc", pc_o, 0);
        check("rst_busy", busy, 0);
`ifdef IFETCH_PERF_EN
        check("rst_fetch_cnt", perf_fetch_cnt, 0);
        check("rst_stall_cnt", perf_stall_cnt, 0);
`endif
        expq.delete();
        flush_pend = 0;
        m_state = M_IDLE;
        m_pc = 8'h00;
        m_fetch = '0;
        m_stall = '0;
        rst_n = 1;
    endtask

    initial begin
        logic [15:0] v40;
        logic [7:0]  held;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        v40 = mem[8'h40];

        // Start and full-rate streaming
        do_reset();
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("t1_cs", mem_cs, 1);
        check("t1_addr", mem_addr, 0);
        step(0, 0, 0, 0, 1);
        check("t1_valid", instr_valid, 1);
        check("t1_instr", instr, 16'h1111);
        check("t1_ipc", instr_pc, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

        // Backpressure: exactly DEPTH pushes, then hold
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
        check("t2_pc", pc_o, 2);
        check("t2_cs", mem_cs, 0);
        check("t2_head", instr, 16'h1111);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

        // Redirect with a full FIFO
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 8'h40, 0);
        step(0, 0, 0, 0, 0);
        check("t3_valid", instr_valid, 0);
        check("t3_addr", mem_addr, 8'h40);
        step(0, 0, 0, 0, 1);
        check("t3_instr", instr, v40);
        check("t3_ipc", instr_pc, 8'h40);

        // PC wrap
        step(0, 0, 1, 8'hFF, 1);
        step(0, 0, 0, 0, 1);
        check("t4_addr_ff", mem_addr, 8'hFF);
        step(0, 0, 0, 0, 1);
        check("t4_ipc", instr_pc, 8'hFF);
        check("t4_addr_wrap", mem_addr, 8'h00);

        // Halt, drain, resume, halt with redirect
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("t5_cs", mem_cs, 0);
        held = pc_o;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        check("t5_drained", instr_valid, 0);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("t5_resume_cs", mem_cs, 1);
        check("t5_resume_addr", mem_addr, held);
        step(0, 1, 1, 8'h80, 1);
        step(0, 0, 0, 0, 1);
        check("t5_rd_pc", pc_o, 8'h80);
        check("t5_rd_cs", mem_cs, 0);
        step(0, 0, 0, 0, 1);

`ifdef IFETCH_PERF_EN
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("t6_fetch_cnt", perf_fetch_cnt, 2);
        check("t6_stall_cnt", perf_stall_cnt, 3);
        do_reset();
`endif

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bit         h, s, r, rd;
            logic [7:0] rp;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                h  = ($urandom_range(0, 15) == 0);
                s  = !h && ($urandom_range(0, 7) == 0);
                r  = ($urandom_range(0, 15) == 0);
                rp = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 255)) : 8'($urandom);
                rd = ($urandom_range(0, 9) < 7);
                step(s, h, r, rp, rd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
